// File: rtl/ddr_test_pkg.sv
// ddr_test_pkg
//   Shared types and helpers for the DDR3 test host.
//   - state_e : host sequencer states
//   - cmd_e   : kind of command started from IDLE
//   - pat()   : test pattern for a location, seed XOR location index
//               (evaluated on 32 bits and truncated by the caller, so DATA_W <= 32)
package ddr_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CMD_WR,
        CMD_RD,
        CMD_SWEEP
    } cmd_e;

    function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] idx);
        return seed ^ idx;
    endfunction

endpackage

// File: rtl/ddr_btn_debounce.sv
// ddr_btn_debounce
//   Raw push-button conditioner: 2-FF synchroniser, debounce counter and
//   rising-edge pulse generator.
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     btn_raw   in   raw (asynchronous, bouncy) button level
//     btn_pulse out  one-cycle pulse when a debounced press is accepted
//   A level change is accepted only after the synchronised input has differed
//   from the accepted level for DEBOUNCE_CYC consecutive cycles.
module ddr_btn_debounce
    import ddr_test_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        pulse_d  = 1'b0;
        cnt_d    = '0;
        // Any cycle where the input agrees with the accepted level restarts the count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/ddr_test_host.sv
// ddr_test_host
//   Stimulus/checker host for the DDR3 command state machine. Debounces three
//   buttons and runs a single WRITE, a single READ, or a sweep over NUM_LOCS
//   locations (write all, read back all, compare against the pattern).
//   Ports:
//     CLK, RESET_n                 clock, asynchronous active-low reset
//     BTN_WR / BTN_RD / BTN_SWEEP  raw buttons
//     SEED, ROW_BASE, COL_BASE, BA_BASE  command setup, latched at command start
//     CMD_DONE, DQ_read            completion pulse and read data from the command SM
//     WRITE, READ                  one-cycle requests to the command SM
//     Addr_Row, Addr_Column, BA_in, Data_input  request address / write data
//     LAST_READ                    last captured read data
//     BUSY, PASS, FAIL, TIMEOUT    status flags
//     ERR_CNT                      saturating mismatch count
//   Build option DDR_TEST_ERRLOG_EN adds ERR_COL / ERR_EXP / ERR_GOT holding
//   the first mismatch of a sweep.
module ddr_test_host
    import ddr_test_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ROW_W        = 15,
    parameter int COL_W        = 10,
    parameter int BA_W         = 3,
    parameter int NUM_LOCS     = 16,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int TIMEOUT_CYC  = 1024,
    parameter int ERR_W        = 8
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              BTN_WR,
    input  logic              BTN_RD,
    input  logic              BTN_SWEEP,
    input  logic [DATA_W-1:0] SEED,
    input  logic [ROW_W-1:0]  ROW_BASE,
    input  logic [COL_W-1:0]  COL_BASE,
    input  logic [BA_W-1:0]   BA_BASE,
    input  logic              CMD_DONE,
    input  logic [DATA_W-1:0] DQ_read,
    output logic              WRITE,
    output logic              READ,
    output logic [ROW_W-1:0]  Addr_Row,
    output logic [COL_W-1:0]  Addr_Column,
    output logic [BA_W-1:0]   BA_in,
    output logic [DATA_W-1:0] Data_input,
    output logic [DATA_W-1:0] LAST_READ,
    output logic              BUSY,
    output logic              PASS,
    output logic              FAIL,
    output logic              TIMEOUT,
    output logic [ERR_W-1:0]  ERR_CNT
`ifdef DDR_TEST_ERRLOG_EN
    ,
    output logic [COL_W-1:0]  ERR_COL,
    output logic [DATA_W-1:0] ERR_EXP,
    output logic [DATA_W-1:0] ERR_GOT
`endif
);

    localparam int IDX_W = (NUM_LOCS > 1) ? $clog2(NUM_LOCS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LOCS - 1);

    logic wr_pulse, rd_pulse, sweep_pulse;

    ddr_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_wr (
        .clk(CLK), .rst_n(RESET_n), .btn_raw(BTN_WR), .btn_pulse(wr_pulse));
    ddr_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_rd (
        .clk(CLK), .rst_n(RESET_n), .btn_raw(BTN_RD), .btn_pulse(rd_pulse));
    ddr_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sweep (
        .clk(CLK), .rst_n(RESET_n), .btn_raw(BTN_SWEEP), .btn_pulse(sweep_pulse));

    state_e            state_q, state_d;
    cmd_e              kind_q, kind_d;
    logic              rd_phase_q, rd_phase_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] last_read_q, last_read_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
`ifdef DDR_TEST_ERRLOG_EN
    logic [COL_W-1:0]  err_col_q, err_col_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;
    logic [DATA_W-1:0] err_got_q, err_got_d;
`endif

    logic [COL_W-1:0]  cur_col;
    logic [DATA_W-1:0] cur_pat;
    logic              tmo_hit;

    // Column wraps modulo 2**COL_W through the natural width of the adder.
    assign cur_col = col_q + COL_W'(idx_q);
    assign cur_pat = DATA_W'(pat(32'(seed_q), 32'(idx_q)));
    assign tmo_hit = (timer_q >= TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        rd_phase_d  = rd_phase_q;
        idx_d       = idx_q;
        seed_d      = seed_q;
        row_d       = row_q;
        col_d       = col_q;
        ba_d        = ba_q;
        timer_d     = timer_q;
        last_read_d = last_read_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        err_cnt_d   = err_cnt_q;
`ifdef DDR_TEST_ERRLOG_EN
        err_col_d   = err_col_q;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Button pulses arriving outside IDLE are simply never looked at.
                if (sweep_pulse || wr_pulse || rd_pulse) begin
                    seed_d     = SEED;
                    row_d      = ROW_BASE;
                    col_d      = COL_BASE;
                    ba_d       = BA_BASE;
                    idx_d      = '0;
                    rd_phase_d = 1'b0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    timeout_d  = 1'b0;
                    if (sweep_pulse) begin
                        kind_d    = CMD_SWEEP;
                        err_cnt_d = '0;
`ifdef DDR_TEST_ERRLOG_EN
                        err_col_d = '0;
                        err_exp_d = '0;
                        err_got_d = '0;
`endif
                        state_d   = ST_WR_ISSUE;
                    end else if (wr_pulse) begin
                        kind_d  = CMD_WR;
                        state_d = ST_WR_ISSUE;
                    end else begin
                        kind_d  = CMD_RD;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_WR_ISSUE: begin
                timer_d = '0;
                state_d = ST_WR_WAIT;
            end
            ST_RD_ISSUE: begin
                timer_d = '0;
                state_d = ST_RD_WAIT;
            end
            ST_WR_WAIT: begin
                if (CMD_DONE) begin
                    state_d = (kind_q == CMD_SWEEP) ? ST_NEXT : ST_DONE;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (CMD_DONE) begin
                    last_read_d = DQ_read;
                    state_d     = (kind_q == CMD_SWEEP) ? ST_CHECK : ST_DONE;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (last_read_q != cur_pat) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
`ifdef DDR_TEST_ERRLOG_EN
                    // The counter never returns to zero within a sweep, so zero marks "first".
                    if (err_cnt_q == '0) begin
                        err_col_d = cur_col;
                        err_exp_d = cur_pat;
                        err_got_d = last_read_q;
                    end
`endif
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    if (!rd_phase_q) begin
                        idx_d      = '0;
                        rd_phase_d = 1'b1;
                        state_d    = ST_RD_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = rd_phase_q ? ST_RD_ISSUE : ST_WR_ISSUE;
                end
            end
            ST_DONE: begin
                if (kind_q == CMD_SWEEP) begin
                    pass_d = (err_cnt_q == '0) && !timeout_q;
                    fail_d = !((err_cnt_q == '0) && !timeout_q);
                end else begin
                    pass_d = !timeout_q;
                    fail_d = timeout_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            kind_q      <= CMD_WR;
            rd_phase_q  <= 1'b0;
            idx_q       <= '0;
            seed_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ba_q        <= '0;
            timer_q     <= '0;
            last_read_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
`ifdef DDR_TEST_ERRLOG_EN
            err_col_q   <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            rd_phase_q  <= rd_phase_d;
            idx_q       <= idx_d;
            seed_q      <= seed_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ba_q        <= ba_d;
            timer_q     <= timer_d;
            last_read_q <= last_read_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
`ifdef DDR_TEST_ERRLOG_EN
            err_col_q   <= err_col_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
`endif
        end
    end

    // Requests and BUSY decode straight from the state flop, so reset clears them at once.
    assign WRITE       = (state_q == ST_WR_ISSUE);
    assign READ        = (state_q == ST_RD_ISSUE);
    assign BUSY        = (state_q != ST_IDLE);
    assign Addr_Row    = row_q;
    assign Addr_Column = cur_col;
    assign BA_in       = ba_q;
    assign Data_input  = cur_pat;
    assign LAST_READ   = last_read_q;
    assign PASS        = pass_q;
    assign FAIL        = fail_q;
    assign TIMEOUT     = timeout_q;
    assign ERR_CNT     = err_cnt_q;
`ifdef DDR_TEST_ERRLOG_EN
    assign ERR_COL     = err_col_q;
    assign ERR_EXP     = err_exp_q;
    assign ERR_GOT     = err_got_q;
`endif

endmodule

// File: tb/tb_ddr_test_host.sv
// tb_ddr_test_host
//   Bench for ddr_test_host with short debounce/timeout, 4-location sweeps and a
//   2-bit error counter. A memory-like responder answers WRITE/READ with
//   CMD_DONE after a random latency and can corrupt chosen read columns or
//   withhold completion. Expectations come from the sweep rules directly.
//   Honours DDR_TEST_ERRLOG_EN.
module tb_ddr_test_host;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        BTN_WR, BTN_RD, BTN_SWEEP;
    logic [7:0]  SEED;
    logic [14:0] ROW_BASE;
    logic [9:0]  COL_BASE;
    logic [2:0]  BA_BASE;
    logic        CMD_DONE;
    logic [7:0]  DQ_read;
    logic        WRITE, READ;
    logic [14:0] Addr_Row;
    logic [9:0]  Addr_Column;
    logic [2:0]  BA_in;
    logic [7:0]  Data_input;
    logic [7:0]  LAST_READ;
    logic        BUSY, PASS, FAIL, TIMEOUT;
    logic [1:0]  ERR_CNT;
`ifdef DDR_TEST_ERRLOG_EN
    logic [9:0]  ERR_COL;
    logic [7:0]  ERR_EXP;
    logic [7:0]  ERR_GOT;
`endif

    ddr_test_host #(
        .DATA_W(8), .ROW_W(15), .COL_W(10), .BA_W(3), .NUM_LOCS(4),
        .DEBOUNCE_CYC(4), .TIMEOUT_CYC(16), .ERR_W(2)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .BTN_WR(BTN_WR), .BTN_RD(BTN_RD), .BTN_SWEEP(BTN_SWEEP),
        .SEED(SEED), .ROW_BASE(ROW_BASE), .COL_BASE(COL_BASE), .BA_BASE(BA_BASE),
        .CMD_DONE(CMD_DONE), .DQ_read(DQ_read),
        .WRITE(WRITE), .READ(READ),
        .Addr_Row(Addr_Row), .Addr_Column(Addr_Column), .BA_in(BA_in),
        .Data_input(Data_input), .LAST_READ(LAST_READ),
        .BUSY(BUSY), .PASS(PASS), .FAIL(FAIL), .TIMEOUT(TIMEOUT),
        .ERR_CNT(ERR_CNT)
`ifdef DDR_TEST_ERRLOG_EN
        , .ERR_COL(ERR_COL), .ERR_EXP(ERR_EXP), .ERR_GOT(ERR_GOT)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder state and request log
    logic [7:0] mem [0:1023];
    logic [7:0] corrupt_map [int];
    bit         withhold = 1'b0;
    int         lat_min = 1, lat_max = 4;
    int         log_kind[$];   // 1 = write, 2 = read
    int         log_col[$];
    int         log_data[$];
    int         log_rowba[$];
    int         log_cyc[$];

    initial begin
        int         pend;
        logic [7:0] pend_data;
        logic [9:0] pend_col;
        pend = 0;
        pend_data = '0;
        pend_col = '0;
        CMD_DONE = 1'b0;
        DQ_read = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        forever begin
            @(negedge CLK);
            CMD_DONE = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (BUSY) check("addr_held", Addr_Column, pend_col);
                    CMD_DONE = 1'b1;
                    DQ_read = pend_data;
                end
            end
            if (WRITE || READ) begin
                log_kind.push_back(WRITE ? 1 : 2);
                log_col.push_back(int'(Addr_Column));
                log_data.push_back(int'(Data_input));
                log_rowba.push_back(int'({Addr_Row, BA_in}));
                log_cyc.push_back(cyc);
                pend_col = Addr_Column;
                if (WRITE) begin
                    mem[Addr_Column] = Data_input;
                    pend_data = 8'($urandom);
                end else if (corrupt_map.exists(int'(Addr_Column))) begin
                    pend_data = corrupt_map[int'(Addr_Column)];
                end else begin
                    pend_data = mem[Addr_Column];
                end
                if (!withhold) pend = $urandom_range(lat_max, lat_min);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic log_clear();
        log_kind.delete();
        log_col.delete();
        log_data.delete();
        log_rowba.delete();
        log_cyc.delete();
    endtask

    // which: 0 = write, 1 = read, 2 = sweep
    task automatic press(input int which);
        @(negedge CLK);
        if (which == 0) BTN_WR = 1'b1;
        else if (which == 1) BTN_RD = 1'b1;
        else BTN_SWEEP = 1'b1;
        tick(8);
        BTN_WR = 1'b0;
        BTN_RD = 1'b0;
        BTN_SWEEP = 1'b0;
        tick(8);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (BUSY && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_idle"}, BUSY, 1'b0);
    endtask

    // Sweep of 4 locations; expectations follow from seed, column base and
    // whatever read corruption corrupt_map holds.
    task automatic run_sweep(input logic [7:0] seed, input logic [9:0] cb, input bit mid_rd);
        int         exp_err, first, n_ok;
        logic [9:0] c, first_col;
        logic [7:0] p, rd, last_exp, first_exp, first_got;
        exp_err = 0;
        first = -1;
        first_col = '0;
        first_exp = '0;
        first_got = '0;
        last_exp = '0;
        SEED = seed;
        COL_BASE = cb;
        log_clear();
        press(2);
        if (mid_rd) begin
            check("busy_mid_sweep", BUSY, 1'b1);
            press(1);
        end
        wait_idle("sweep", 400);
        if (mid_rd) tick(20);
        check("sweep_nreq", log_kind.size(), 8);
        n_ok = (log_kind.size() == 8) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            c = cb + 10'(i);
            p = seed ^ 8'(i);
            if (n_ok == 1) begin
                check("sweep_wr", log_kind[i] * 1048576 + log_col[i] * 256 + log_data[i],
                      1 * 1048576 + int'(c) * 256 + int'(p));
                check("sweep_rd", log_kind[4 + i] * 1048576 + log_col[4 + i] * 256,
                      2 * 1048576 + int'(c) * 256);
            end
            rd = corrupt_map.exists(int'(c)) ? corrupt_map[int'(c)] : p;
            if (rd != p) begin
                exp_err++;
                if (first < 0) begin
                    first = i;
                    first_col = c;
                    first_exp = p;
                    first_got = rd;
                end
            end
            last_exp = rd;
        end
        if (n_ok == 1) check("sweep_rowba", log_rowba[0], int'({ROW_BASE, BA_BASE}));
        check("sweep_pass", PASS, exp_err == 0);
        check("sweep_fail", FAIL, exp_err != 0);
        check("sweep_timeout", TIMEOUT, 1'b0);
        check("sweep_errcnt", ERR_CNT, (exp_err > 3) ? 3 : exp_err);
        check("sweep_last_read", LAST_READ, last_exp);
`ifdef DDR_TEST_ERRLOG_EN
        check("errlog_col", ERR_COL, first_col);
        check("errlog_exp", ERR_EXP, first_exp);
        check("errlog_got", ERR_GOT, first_got);
`endif
        tick(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t_end, el;
        logic [7:0] s, sd;
        logic [9:0] cb, cc;

        RESET_n = 1'b0;
        BTN_WR = 1'b0;
        BTN_RD = 1'b0;
        BTN_SWEEP = 1'b0;
        SEED = 8'hA5;
        ROW_BASE = 15'($urandom);
        COL_BASE = 10'd1;
        BA_BASE = 3'b101;
        tick(3);
        check("reset_outputs", {WRITE, READ, BUSY, PASS, FAIL, TIMEOUT, ERR_CNT, LAST_READ,
                                Addr_Column, Data_input, Addr_Row, BA_in}, '0);
`ifdef DDR_TEST_ERRLOG_EN
        check("reset_errlog", {ERR_COL, ERR_EXP, ERR_GOT}, '0);
`endif
        RESET_n = 1'b1;
        tick(3);

        // Bouncing write button: 1-0-1 then held 6 cycles -> exactly one write
        log_clear();
        @(negedge CLK) BTN_WR = 1'b1;
        @(negedge CLK) BTN_WR = 1'b0;
        @(negedge CLK) BTN_WR = 1'b1;
        tick(6);
        BTN_WR = 1'b0;
        tick(10);
        wait_idle("bounce_wr", 100);
        tick(10);
        check("bounce_nreq", log_kind.size(), 1);
        if (log_kind.size() == 1) begin
            check("bounce_wr_req", log_kind[0] * 1048576 + log_col[0] * 256 + log_data[0],
                  1 * 1048576 + 1 * 256 + 8'hA5);
        end
        check("bounce_pass", {PASS, FAIL, TIMEOUT}, 3'b100);

        // Echo sweep from column 1
        corrupt_map.delete();
        run_sweep(8'hA5, 10'd1, 1'b0);

        // Column 3 read corrupted to 0
        corrupt_map.delete();
        corrupt_map[3] = 8'h00;
        run_sweep(8'hA5, 10'd1, 1'b0);
        corrupt_map.delete();

        // Completion withheld after the first write -> timeout
        withhold = 1'b1;
        log_clear();
        SEED = 8'h3C;
        COL_BASE = 10'd7;
        press(0);
        wait_idle("tmo", 100);
        t_end = cyc;
        check("tmo_nreq", log_kind.size(), 1);
        check("tmo_flags", {TIMEOUT, FAIL, PASS}, 3'b110);
        el = (log_cyc.size() > 0) ? (t_end - log_cyc[0]) : -1;
        check("tmo_window", (el >= 16 && el <= 20), 1'b1);
        withhold = 1'b0;
        tick(4);

        // Column wrap, with a read press during the sweep that must be dropped
        lat_min = 2;
        lat_max = 5;
        run_sweep(8'h96, 10'h3FE, 1'b1);
        lat_min = 1;
        lat_max = 4;

        // Single read of a location the sweep just wrote (index 1 -> column 3FF)
        log_clear();
        COL_BASE = 10'h3FF;
        SEED = 8'h00;
        press(1);
        wait_idle("single_rd", 100);
        check("single_rd_nreq", log_kind.size(), 1);
        if (log_kind.size() == 1) check("single_rd_col", log_kind[0] * 4096 + log_col[0], 2 * 4096 + 10'h3FF);
        check("single_rd_data", LAST_READ, 8'h96 ^ 8'h01);
        check("single_rd_flags", {PASS, FAIL, TIMEOUT}, 3'b100);

        // Every read corrupted: 4 mismatches saturate a 2-bit counter at 3
        corrupt_map.delete();
        for (int i = 0; i < 4; i++) corrupt_map[10 + i] = 8'h00;
        run_sweep(8'h5A, 10'd10, 1'b0);
        corrupt_map.delete();

        // Randomised sweeps
        for (int k = 0; k < 6; k++) begin
            s = 8'($urandom);
            cb = 10'($urandom);
            ROW_BASE = 15'($urandom);
            BA_BASE = 3'($urandom);
            lat_min = $urandom_range(2, 1);
            lat_max = $urandom_range(6, 2);
            corrupt_map.delete();
            for (int i = 0; i < 4; i++) begin
                cc = cb + 10'(i);
                sd = s ^ 8'(i);
                if ($urandom_range(2, 0) == 0) corrupt_map[int'(cc)] = sd ^ 8'($urandom_range(255, 1));
            end
            run_sweep(s, cb, 1'b0);
        end
        corrupt_map.delete();
        lat_min = 1;
        lat_max = 4;

        // Reset during the read phase
        log_clear();
        SEED = 8'h11;
        COL_BASE = 10'd100;
        press(2);
        el = 0;
        while (log_kind.size() < 5 && el < 300) begin
            @(negedge CLK);
            el++;
        end
        check("reached_read_phase", log_kind.size() >= 5, 1'b1);
        @(negedge CLK);
        #2 RESET_n = 1'b0;
        #1 check("async_reset_outputs", {WRITE, READ, BUSY, PASS, FAIL, TIMEOUT, ERR_CNT, LAST_READ,
                                          Addr_Column, Data_input, Addr_Row, BA_in}, '0);
`ifdef DDR_TEST_ERRLOG_EN
        check("async_reset_errlog", {ERR_COL, ERR_EXP, ERR_GOT}, '0);
`endif
        t_end = log_kind.size();
        tick(3);
        RESET_n = 1'b1;
        tick(40);
        check("no_req_after_reset", log_kind.size(), t_end);
        check("idle_after_reset", BUSY, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
